// File: rtl/indicator_if.sv
// indicator_if -- request/status bundle for the indicator blip sequencer.
//   trig_short : one-cycle request for a sequence of short blips
//   trig_long  : one-cycle request for a sequence of long blips
//   count      : number of blips (0 means 1), sampled with the trigger
//   out        : registered LED/buzzer drive
//   busy       : a sequence is in progress
//   done       : one-cycle pulse when a sequence completes
// master drives the requests, slave (the indicator) drives the status.
interface indicator_if;
  logic       trig_short;
  logic       trig_long;
  logic [2:0] count;
  logic       out;
  logic       busy;
  logic       done;

  modport master (
    output trig_short, trig_long, count,
    input  out, busy, done
  );

  modport slave (
    input  trig_short, trig_long, count,
    output out, busy, done
  );
endinterface

// File: rtl/indicator.sv
// indicator -- drives an LED/buzzer with n blips of a short or long on-time,
// separated by fixed gaps, all timed in prescaler ticks of 2^TICK_N clocks.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : indicator_if.slave (trig_short, trig_long, count in;
//           out, busy, done out)
// Parameters: ACTIVE_OUT (level of out while on), TICK_N (prescaler width,
//   >= 1), SHORT_TICKS / LONG_TICKS / GAP_TICKS (phase lengths in ticks, >= 1).
// Build option: define INDICATOR_QUEUE_EN to keep one pending request that
//   arrives while busy (last one wins); without it such triggers are dropped.
module indicator #(
  parameter logic        ACTIVE_OUT  = 1'b0,
  parameter int unsigned TICK_N      = 14,
  parameter int unsigned SHORT_TICKS = 8,
  parameter int unsigned LONG_TICKS  = 64,
  parameter int unsigned GAP_TICKS   = 8
) (
  input  logic        clock,
  input  logic        reset,
  indicator_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int unsigned MAX_LG = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
  localparam int unsigned MAXT   = (SHORT_TICKS > MAX_LG) ? SHORT_TICKS : MAX_LG;
  localparam int unsigned CW     = $clog2(MAXT + 1);

  logic [1:0]        r_state;
  logic [TICK_N-1:0] r_pre;
  logic [CW-1:0]     r_ticks;
  logic              r_long;
  logic [2:0]        r_rem;
  logic              r_out;
  logic              r_done;

  logic              w_trig;
  logic              w_idle;
  logic              w_tick;
  logic [CW-1:0]     w_limit;
  logic              w_phase_end;
  logic              w_start;
  logic              w_start_long;
  logic [2:0]        w_sel_cnt;
  logic [2:0]        w_start_cnt;

  assign w_trig = bus.trig_short | bus.trig_long;
  assign w_idle = (r_state == IDLE);
  assign w_tick = &r_pre;

  // Last tick index of the current phase; the phase ends on the edge where
  // the final tick of that index completes.
  always_comb begin
    w_limit = CW'(SHORT_TICKS - 1);
    if (r_state == GAP)
      w_limit = CW'(GAP_TICKS - 1);
    else if (r_long)
      w_limit = CW'(LONG_TICKS - 1);
  end

  assign w_phase_end = w_tick && (r_ticks == w_limit);

`ifdef INDICATOR_QUEUE_EN
  logic       r_pend_valid;
  logic       r_pend_long;
  logic [2:0] r_pend_cnt;

  // A fresh trigger in IDLE takes precedence over the stored one (last wins);
  // either way the pending slot is consumed when a sequence starts.
  assign w_start      = w_idle && (w_trig || r_pend_valid);
  assign w_start_long = w_trig ? bus.trig_long : r_pend_long;
  assign w_sel_cnt    = w_trig ? bus.count : r_pend_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_long  <= 1'b0;
      r_pend_cnt   <= '0;
    end else if (!w_idle && w_trig) begin
      r_pend_valid <= 1'b1;
      r_pend_long  <= bus.trig_long;
      r_pend_cnt   <= bus.count;
    end else if (w_start) begin
      r_pend_valid <= 1'b0;
    end
  end
`else
  assign w_start      = w_idle && w_trig;
  assign w_start_long = bus.trig_long;
  assign w_sel_cnt    = bus.count;
`endif

  assign w_start_cnt = (w_sel_cnt == 3'd0) ? 3'd1 : w_sel_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_ticks <= '0;
      r_long  <= 1'b0;
      r_rem   <= '0;
      r_out   <= ~ACTIVE_OUT;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_pre   <= '0;
          r_ticks <= '0;
          if (w_start) begin
            r_state <= ON;
            r_long  <= w_start_long;
            r_rem   <= w_start_cnt;
            r_out   <= ACTIVE_OUT;
          end
        end
        ON: begin
          if (w_phase_end) begin
            r_pre   <= '0;
            r_ticks <= '0;
            r_out   <= ~ACTIVE_OUT;
            if (r_rem > 3'd1) begin
              r_state <= GAP;
              r_rem   <= r_rem - 3'd1;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_pre <= r_pre + 1'b1;
            if (w_tick)
              r_ticks <= r_ticks + 1'b1;
          end
        end
        GAP: begin
          if (w_phase_end) begin
            r_pre   <= '0;
            r_ticks <= '0;
            r_state <= ON;
            r_out   <= ACTIVE_OUT;
          end else begin
            r_pre <= r_pre + 1'b1;
            if (w_tick)
              r_ticks <= r_ticks + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pre   <= '0;
          r_ticks <= '0;
          r_out   <= ~ACTIVE_OUT;
        end
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = ~w_idle;
  assign bus.done = r_done;

endmodule

// File: tb/tb_indicator.sv
// tb_indicator -- scoreboard bench for indicator with TICK_N=2, SHORT_TICKS=2,
// LONG_TICKS=4, GAP_TICKS=1, ACTIVE_OUT=0 (short blip 8 clocks, long 16,
// gap 4). Each scenario pushes the expected {out,busy,done} per cycle when it
// drives a trigger, then pops and compares one entry per falling edge.
module tb_indicator;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [2:0] exp_q[$];

  indicator_if bus ();

  indicator #(
    .ACTIVE_OUT (1'b0),
    .TICK_N     (2),
    .SHORT_TICKS(2),
    .LONG_TICKS (4),
    .GAP_TICKS  (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected trace of one sequence: n blips of on_clk low cycles separated by
  // gap_clk high-but-busy cycles, then the done cycle, then idle cycles.
  function automatic void push_seq(int n, int on_clk, int gap_clk, int idle_after);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < on_clk; i++) exp_q.push_back(3'b010);
      if (b != n - 1)
        for (int i = 0; i < gap_clk; i++) exp_q.push_back(3'b110);
    end
    exp_q.push_back(3'b101);
    for (int i = 0; i < idle_after; i++) exp_q.push_back(3'b100);
  endfunction

  task automatic test_reset();
    logic [2:0] got;
    reset = 1'b1;
    bus.trig_short = 1'b0;
    bus.trig_long  = 1'b0;
    bus.count      = 3'd0;
    #12;
    got = {bus.out, bus.busy, bus.done};
    total++;
    if (got !== 3'b100) begin
      bad++;
      $display("FAIL reset_hold: out,busy,done=%b expected 100", got);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(3'b100);
    while (exp_q.size() != 0) begin
      @(negedge clock);
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp_q[0]) begin
        bad++;
        $display("FAIL reset_idle: out,busy,done=%b expected %b", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_short_single();
    logic [2:0] got, exp;
    int c;
    @(negedge clock);
    bus.trig_short = 1'b1;
    bus.count      = 3'd1;
    push_seq(1, 8, 4, 2);
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      if (c == 0) bus.trig_short = 1'b0;
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL short1 cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      c++;
    end
  endtask

  // count is changed to 7 right after the trigger; the latched 3 must hold.
  task automatic test_short_triple();
    logic [2:0] got, exp;
    int c;
    @(negedge clock);
    bus.trig_short = 1'b1;
    bus.count      = 3'd3;
    push_seq(3, 8, 4, 2);
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      if (c == 0) begin
        bus.trig_short = 1'b0;
        bus.count      = 3'd7;
      end
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL short3 cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      c++;
    end
  endtask

  task automatic test_long_wins();
    logic [2:0] got, exp;
    int c;
    @(negedge clock);
    bus.trig_short = 1'b1;
    bus.trig_long  = 1'b1;
    bus.count      = 3'd0;
    push_seq(1, 16, 4, 2);
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      if (c == 0) begin
        bus.trig_short = 1'b0;
        bus.trig_long  = 1'b0;
      end
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL long_wins cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      c++;
    end
  endtask

  task automatic test_reset_midblip();
    logic [2:0] got, exp;
    int c;
    @(negedge clock);
    bus.trig_long = 1'b1;
    bus.count     = 3'd1;
    for (int i = 0; i < 5; i++) exp_q.push_back(3'b010);
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      if (c == 0) bus.trig_long = 1'b0;
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midblip_pre cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      c++;
    end
    #2 reset = 1'b1;
    #1;
    got = {bus.out, bus.busy, bus.done};
    total++;
    if (got !== 3'b100) begin
      bad++;
      $display("FAIL midblip_async: out,busy,done=%b expected 100", got);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) exp_q.push_back(3'b100);
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midblip_after cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      c++;
    end
    @(negedge clock);
    bus.trig_short = 1'b1;
    bus.count      = 3'd1;
    push_seq(1, 8, 4, 2);
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      if (c == 0) bus.trig_short = 1'b0;
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midblip_fresh cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      c++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got, exp;
    int c;
    @(negedge clock);
    bus.trig_short = 1'b1;
    bus.count      = 3'd1;
`ifdef INDICATOR_QUEUE_EN
    push_seq(1, 8, 4, 0);
    push_seq(1, 16, 4, 3);
`else
    push_seq(1, 8, 4, 20);
`endif
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      exp = exp_q.pop_front();
      got = {bus.out, bus.busy, bus.done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back2back cyc%0d: out,busy,done=%b expected %b", c, got, exp);
      end
      if (c == 0) bus.trig_short = 1'b0;
      if (c == 2) begin
        bus.trig_long = 1'b1;
        bus.count     = 3'd1;
      end
      if (c == 3) bus.trig_long = 1'b0;
      c++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_short_single();
    test_short_triple();
    test_long_wins();
    test_reset_midblip();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/indicator.md
INDICATOR -- requirements
Module: indicator

Interface
REQ-001 SHALL have parameter ACTIVE_OUT, default 1'b0: level of out while the indicator is on (active-low drive).
REQ-002 SHALL have parameter TICK_N, default 14: prescaler width; one tick = 2^TICK_N clocks.
REQ-003 SHALL have parameters SHORT_TICKS (default 8), LONG_TICKS (default 64) and GAP_TICKS (default 8): on-time of a short blip, on-time of a long blip and inter-blip gap, in ticks, all >=1.
REQ-004 SHALL have port clock, input, 1 bit: system clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port trig_short, input, 1 bit: one-cycle request for a short-blip sequence.
REQ-007 SHALL have port trig_long, input, 1 bit: one-cycle request for a long-blip sequence.
REQ-008 SHALL have port count, input, 3 bits: number of blips, sampled with the trigger; 0 is treated as 1.
REQ-009 SHALL have port out, output, 1 bit: registered drive to the LED or buzzer.
REQ-010 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-012 SHALL implement the FSM states IDLE, ON and GAP, with out = ACTIVE_OUT only in ON and ~ACTIVE_OUT otherwise.
REQ-013 SHALL, in IDLE with either trigger high at a clock edge, latch length, repeats and count, then enter ON at that edge, so out is active from the next cycle.
REQ-014 SHALL select length LONG_TICKS when trig_long and trig_short are high together (long wins).
REQ-015 SHALL hold the prescaler at 0 in IDLE and clear it on every state entry, so each phase lasts exactly ticks*2^TICK_N clocks.
REQ-016 SHALL use a tick counter wide enough for max(LONG_TICKS, GAP_TICKS) and clear it on every state entry.
REQ-017 SHALL, in ON after length ticks: go to GAP and decrement remaining if remaining>1, else go to IDLE with done pulsed for that one cycle.
REQ-018 SHALL, in GAP after GAP_TICKS ticks, return to ON.
REQ-019 SHALL drive busy = (state != IDLE).
REQ-020 SHALL total sequence duration as n*length + (n-1)*GAP_TICKS ticks, where n = max(count,1).
REQ-021 SHALL ignore triggers while busy, except as given in REQ-026.
REQ-022 SHALL ignore changes on count outside the trigger cycle.

Reset
REQ-023 SHALL, on reset asserted at any time including mid-sequence, immediately force state IDLE, out = ~ACTIVE_OUT, busy = 0, done = 0, and clear the prescaler, tick counter, remaining count and pending request.
REQ-024 SHALL emit no done pulse for a sequence aborted by reset.

Configuration
REQ-025 SHALL use macro INDICATOR_QUEUE_EN to compile in a one-deep pending-request register.
REQ-026 SHALL, with INDICATOR_QUEUE_EN defined:
- a trigger while busy stores length and count in the pending register; a later trigger overwrites it (last wins).
- on the IDLE cycle following done, a valid pending request is started as if triggered that cycle, then cleared.
- out is therefore inactive for exactly one cycle between the queued sequences.
REQ-027 SHALL, without INDICATOR_QUEUE_EN, contain no pending register and drop triggers while busy.

Verification (TICK_N=2, SHORT_TICKS=2, LONG_TICKS=4, GAP_TICKS=1, ACTIVE_OUT=0)
REQ-028 SHALL cover: trig_short, count=1 -> out low for exactly 8 cycles from the next cycle; done high on the cycle out returns high; busy high 8 cycles.
REQ-029 SHALL cover: trig_short, count=3 -> out low 8, high 4, low 8, high 4, low 8; busy 32 cycles; a single done pulse.
REQ-030 SHALL cover: trig_short and trig_long together, count=0 -> one long blip, out low 16 cycles.
REQ-031 SHALL cover: reset asserted 5 cycles into a long blip -> out high, busy 0 at once; no done; a fresh trig_short afterwards gives an 8-cycle blip.
REQ-032 SHALL cover: trig_long issued 3 cycles into a short sequence -> without the macro, ignored (busy 8 cycles total); with INDICATOR_QUEUE_EN, short 8 low, 1 high, then long 16 low, two done pulses.
